// File: rtl/tmds_pkg.sv
// Shared constants and types for the TMDS receive channel.
package tmds_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

    localparam int unsigned OFFSET_MAX = 9;

    typedef enum logic {
        SEARCH,
        LOCKED
    } lock_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into token or data.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_token,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [7:0] q;

    // Undo the optional inversion, then the XOR/XNOR chain; classify control tokens.
    always_comb begin
        q = sym[9] ? ~sym[7:0] : sym[7:0];
        data = '0;
        data[0] = q[0];
        for (int unsigned i = 1; i < 8; i++) begin
            data[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end

        is_token = 1'b1;
        ctrl     = '0;
        case (sym)
            TMDS_CTRL_00: ctrl = 2'b00;
            TMDS_CTRL_01: ctrl = 2'b01;
            TMDS_CTRL_10: ctrl = 2'b10;
            TMDS_CTRL_11: ctrl = 2'b11;
            default:      is_token = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_decoder.sv
// One TMDS receive channel: word alignment by control-token lock, then decode.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned TOKEN_RUN      = 16,
    parameter int unsigned SEARCH_TIMEOUT = 2048,
    parameter int unsigned LOSS_TIMEOUT   = 4096
) (
    input  logic       clk_pix,
    input  logic       rst_pix_n,
    input  logic [9:0] tmds_raw,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int unsigned RUN_W   = $clog2(TOKEN_RUN);
    localparam int unsigned DWELL_W = $clog2(SEARCH_TIMEOUT);
    localparam int unsigned LOSS_W  = $clog2(LOSS_TIMEOUT);

    logic [9:0]         raw_q;
    logic [9:0]         sym_q;
    logic [19:0]        window;
    logic [9:0]         sym_next;
    logic               tok;
    logic [1:0]         dec_ctrl;
    logic [7:0]         dec_data;
    logic [RUN_W-1:0]   run_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [LOSS_W-1:0]  loss_q;
    logic               skip_q;
    logic [3:0]         offset_q;
    lock_state_t        state_q;
    lock_state_t        state_d;
    logic               run_hit;
    logic               dwell_hit;
    logic               loss_hit;

    assign window   = {tmds_raw, raw_q};
    assign sym_next = 10'(window >> offset_q);
    assign offset   = offset_q;
    assign locked   = (state_q == LOCKED);

    tmds_symbol_decode u_dec (
        .sym      (sym_q),
        .is_token (tok),
        .ctrl     (dec_ctrl),
        .data     (dec_data)
    );

    // Stage 1: previous word for the 20-bit window and the aligned symbol.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            raw_q <= '0;
            sym_q <= '0;
        end else begin
            raw_q <= tmds_raw;
            sym_q <= sym_next;
        end
    end

    // Next lock state; the output stage gates on this so locked and outputs move together.
    always_comb begin
        run_hit   = tok && !skip_q && (run_q == RUN_W'(TOKEN_RUN - 1));
        dwell_hit = (dwell_q == DWELL_W'(SEARCH_TIMEOUT - 1));
        loss_hit  = !tok && (loss_q == LOSS_W'(LOSS_TIMEOUT - 1));
        state_d   = state_q;
        case (state_q)
            SEARCH:  if (run_hit)  state_d = LOCKED;
            LOCKED:  if (loss_hit) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
    end

    // Lock FSM with run/dwell/loss timers and the alignment offset.
    // skip_q discards the one stage-1 symbol still sampled at the old offset.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q  <= SEARCH;
            run_q    <= '0;
            dwell_q  <= '0;
            loss_q   <= '0;
            skip_q   <= 1'b0;
            offset_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                SEARCH: begin
                    if (run_hit) begin
                        run_q   <= '0;
                        dwell_q <= '0;
                        loss_q  <= '0;
                        skip_q  <= 1'b0;
                    end else if (dwell_hit) begin
                        offset_q <= (offset_q == 4'(OFFSET_MAX)) ? 4'd0 : offset_q + 4'd1;
                        run_q    <= '0;
                        dwell_q  <= '0;
                        skip_q   <= 1'b1;
                    end else begin
                        run_q   <= (tok && !skip_q) ? run_q + RUN_W'(run_q != '1) : '0;
                        dwell_q <= dwell_q + DWELL_W'(dwell_q != '1);
                        skip_q  <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (tok) begin
                        loss_q <= '0;
                    end else if (loss_hit) begin
                        run_q   <= '0;
                        dwell_q <= '0;
                    end else begin
                        loss_q <= loss_q + LOSS_W'(loss_q != '1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage 2: registered de/ctrl/data, forced idle whenever not locked.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            de   <= 1'b0;
            ctrl <= '0;
            data <= '0;
        end else if (state_d != LOCKED) begin
            de   <= 1'b0;
            ctrl <= '0;
            data <= '0;
        end else if (tok) begin
            de   <= 1'b0;
            ctrl <= dec_ctrl;
            data <= '0;
        end else begin
            de   <= 1'b1;
            ctrl <= '0;
            data <= dec_data;
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder against a symbol-stream reference model.
module tb_tmds_decoder;

    localparam int TOKEN_RUN      = 16;
    localparam int SEARCH_TIMEOUT = 2048;
    localparam int LOSS_TIMEOUT   = 4096;

    logic       clk_pix = 1'b0;
    logic       rst_pix_n = 1'b0;
    logic [9:0] tmds_raw = '0;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic       locked;
    logic [3:0] offset;
    logic [15:0] dut_vec;

    int errors = 0;
    int checks = 0;
    int n = 0;
    int idx = 0;

    // reference model state
    bit         m_locked;
    int         m_off, m_run, m_dwell, m_loss, m_skip;
    logic [9:0] m_sym, m_prev;
    logic       m_de;
    logic [1:0] m_ctrl;
    logic [7:0] m_data;

    bit bq[$];

    tmds_decoder #(
        .TOKEN_RUN      (TOKEN_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .LOSS_TIMEOUT   (LOSS_TIMEOUT)
    ) dut (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .tmds_raw  (tmds_raw),
        .de        (de),
        .ctrl      (ctrl),
        .data      (data),
        .locked    (locked),
        .offset    (offset)
    );

    always #5 clk_pix = ~clk_pix;

    assign dut_vec = {locked, offset, de, ctrl, data};

    function automatic int tok_code(input logic [9:0] s);
        case (s)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] ref_data(input logic [9:0] s);
        logic [7:0] q, d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = ((q[i] ^ q[i-1]) == s[8]);
        return d;
    endfunction

    function automatic logic [9:0] pick(input logic [9:0] newer, input logic [9:0] older, input int off);
        logic [19:0] win;
        win = {newer, older};
        return win[off +: 10];
    endfunction

    function automatic logic [15:0] exp_vec();
        return {m_locked, 4'(m_off), m_de, m_ctrl, m_data};
    endfunction

    task automatic model_reset();
        m_locked = 0; m_off = 0; m_run = 0; m_dwell = 0; m_loss = 0; m_skip = 0;
        m_sym = '0; m_prev = '0; m_de = 0; m_ctrl = '0; m_data = '0;
    endtask

    task automatic model_edge(input logic [9:0] w);
        int tk, old_off;
        tk = tok_code(m_sym);
        old_off = m_off;
        if (!m_locked) begin
            if (tk >= 0 && m_skip == 0 && m_run + 1 >= TOKEN_RUN) begin
                m_locked = 1; m_loss = 0; m_run = 0; m_dwell = 0; m_skip = 0;
            end else if (m_dwell >= SEARCH_TIMEOUT - 1) begin
                m_off = (m_off + 1) % 10; m_run = 0; m_dwell = 0; m_skip = 1;
            end else begin
                m_run = (tk >= 0 && m_skip == 0) ? m_run + 1 : 0;
                m_dwell++;
                m_skip = 0;
            end
        end else begin
            if (tk >= 0) m_loss = 0;
            else if (m_loss >= LOSS_TIMEOUT - 1) begin
                m_locked = 0; m_run = 0; m_dwell = 0;
            end else m_loss++;
        end
        if (!m_locked) begin
            m_de = 0; m_ctrl = '0; m_data = '0;
        end else if (tk >= 0) begin
            m_de = 0; m_ctrl = 2'(tk); m_data = '0;
        end else begin
            m_de = 1; m_ctrl = '0; m_data = ref_data(m_sym);
        end
        m_sym = pick(w, m_prev, old_off);
        m_prev = w;
    endtask

    task automatic step(input logic [9:0] w);
        tmds_raw = w;
        @(posedge clk_pix);
        model_edge(w);
        @(negedge clk_pix);
        idx = n;
        n++;
    endtask

    task automatic do_reset();
        rst_pix_n = 1'b0;
        tmds_raw = 10'($urandom);
        repeat (2) @(negedge clk_pix);
        model_reset();
        n = 0;
        rst_pix_n = 1'b1;
    endtask

    task automatic next_word(input int ntok, inout int sidx, output logic [9:0] w);
        logic [9:0] s;
        while (bq.size() < 10) begin
            if (sidx < ntok) s = 10'h354;
            else if ($urandom_range(0, 3) == 0) s = 10'h354;
            else s = 10'($urandom);
            for (int b = 0; b < 10; b++) bq.push_back(s[b]);
            sidx++;
        end
        for (int b = 0; b < 10; b++) w[b] = bq.pop_front();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            tmds_raw = 10'($urandom);
            @(negedge clk_pix);
            checks++;
            if (dut_vec !== 16'h0) begin
                errors++;
                $display("FAIL reset_hold: got %04h want 0000", dut_vec);
            end
        end
        model_reset();
        n = 0;
        rst_pix_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(10'($urandom));
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reset_release idx %0d: got %04h want %04h", idx, dut_vec, exp_vec());
            end
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_unlocked: got %0b want 0", locked);
        end
    endtask

    task automatic test_aligned_lock();
        logic [9:0] words [20];
        logic [7:0] want [4];
        want = '{8'h00, 8'hFE, 8'h01, 8'hFF};
        for (int i = 0; i < 16; i++) words[i] = 10'h354;
        words[16] = 10'h0AA; words[17] = 10'h355; words[18] = 10'h300; words[19] = 10'h0FF;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(i < 20 ? words[i] : 10'h354);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL aligned idx %0d: got %04h want %04h", idx, dut_vec, exp_vec());
            end
            if (idx == 16) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL aligned_prelock: got %0b want 0", locked);
                end
            end
            if (idx == 17) begin
                checks++;
                if (locked !== 1'b1 || offset !== 4'd0) begin
                    errors++;
                    $display("FAIL aligned_lock: got locked=%0b offset=%0d want 1/0", locked, offset);
                end
            end
            if (idx >= 18 && idx <= 21) begin
                checks++;
                if (de !== 1'b1 || data !== want[idx-18]) begin
                    errors++;
                    $display("FAIL aligned_data: got de=%0b data=%02h want 1/%02h", de, data, want[idx-18]);
                end
            end
        end
    endtask

    task automatic test_control();
        logic [9:0] words [5];
        logic [1:0] want [3];
        words = '{10'h0AB, 10'h154, 10'h2AB, 10'h354, 10'h354};
        want = '{2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 5; i++) begin
            step(words[i]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL control idx %0d: got %04h want %04h", idx, dut_vec, exp_vec());
            end
            if (i >= 2) begin
                checks++;
                if (de !== 1'b0 || ctrl !== want[i-2]) begin
                    errors++;
                    $display("FAIL control_seq: got de=%0b ctrl=%0d want 0/%0d", de, ctrl, want[i-2]);
                end
            end
        end
    endtask

    task automatic test_random_data();
        logic [9:0] w;
        for (int i = 0; i < 200; i++) begin
            w = ($urandom_range(0, 3) == 0) ? 10'h2AB : 10'($urandom);
            step(w);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random idx %0d: got %04h want %04h", idx, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic run_misaligned(input int lead, input int ntok, input int nwords, output int first_lock);
        logic [9:0] w;
        int sidx;
        sidx = 0;
        first_lock = -1;
        bq.delete();
        for (int b = 0; b < lead; b++) bq.push_back(1'($urandom));
        do_reset();
        for (int i = 0; i < nwords; i++) begin
            next_word(ntok, sidx, w);
            step(w);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL misaligned idx %0d: got %04h want %04h", idx, dut_vec, exp_vec());
            end
            if (locked === 1'b1 && first_lock < 0) first_lock = idx;
            if ((idx + 1) % SEARCH_TIMEOUT == 0 && (idx + 1) / SEARCH_TIMEOUT <= lead) begin
                checks++;
                if (offset !== 4'((idx + 1) / SEARCH_TIMEOUT)) begin
                    errors++;
                    $display("FAIL offset_step idx %0d: got %0d want %0d", idx, offset, (idx + 1) / SEARCH_TIMEOUT);
                end
            end
        end
        checks++;
        if (first_lock < 0 || first_lock > lead * SEARCH_TIMEOUT + TOKEN_RUN + 2) begin
            errors++;
            $display("FAIL lock_time lead %0d: got %0d want <= %0d", lead, first_lock, lead * SEARCH_TIMEOUT + TOKEN_RUN + 2);
        end
        checks++;
        if (locked !== 1'b1 || offset !== 4'(lead)) begin
            errors++;
            $display("FAIL lock_offset: got locked=%0b offset=%0d want 1/%0d", locked, offset, lead);
        end
    endtask

    task automatic test_misaligned();
        int fl;
        run_misaligned(3, 6190, 6230, fl);
    endtask

    task automatic test_loss_of_lock();
        logic [9:0] w;
        do_reset();
        for (int i = 0; i < 4240; i++) begin
            w = (i < 20 || i >= 4220) ? 10'h354 : 10'h0AA;
            step(w);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL loss idx %0d: got %04h want %04h", idx, dut_vec, exp_vec());
            end
            if (idx == 4116) begin
                checks++;
                if (locked !== 1'b1 || de !== 1'b1 || data !== 8'h00) begin
                    errors++;
                    $display("FAIL loss_before: got locked=%0b de=%0b data=%02h want 1/1/00", locked, de, data);
                end
            end
            if (idx == 4117) begin
                checks++;
                if (locked !== 1'b0 || de !== 1'b0 || offset !== 4'd0) begin
                    errors++;
                    $display("FAIL loss_drop: got locked=%0b de=%0b offset=%0d want 0/0/0", locked, de, offset);
                end
            end
            if (idx == 4236 || idx == 4237) begin
                checks++;
                if (locked !== (idx == 4237)) begin
                    errors++;
                    $display("FAIL relock idx %0d: got %0b want %0b", idx, locked, idx == 4237);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int fl;
        run_misaligned(5, 10280, 10270, fl);
        #2 rst_pix_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: got %04h want 0000", dut_vec);
        end
        @(negedge clk_pix);
        @(negedge clk_pix);
        model_reset();
        n = 0;
        rst_pix_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(10'h354);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL post_reset idx %0d: got %04h want %04h", idx, dut_vec, exp_vec());
            end
        end
        checks++;
        if (offset !== 4'd0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_relock: got locked=%0b offset=%0d want 1/0", locked, offset);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_aligned_lock();
        test_control();
        test_random_data();
        test_misaligned();
        test_loss_of_lock();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
